// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: reads memory at the PC, hands words to the
// decoder, resolves jumps locally and drives PC increment/load pulses.
module instr_fetch_ctrl #(
    parameter int         ACK_TIMEOUT = 15,
    parameter logic [3:0] JMP_OP      = 4'hC,
    parameter logic [3:0] HALT_OP     = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [7:0]  insaddr,
    output logic        Inc_PC,
    output logic        Load_PC,
    output logic [4:0]  addr,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        IDLE, REQ, JUMP, HOLD, ADV, HALT, ERR
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;

    assign mem_addr = mem_req ? insaddr : 8'h00;

    // Outputs are registered alongside the transition that enters each state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 8'h00;
            instr       <= 16'h0000;
            Inc_PC      <= 1'b0;
            Load_PC     <= 1'b0;
            addr        <= 5'd0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            Inc_PC      <= 1'b0;
            Load_PC     <= 1'b0;
            addr        <= 5'd0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        instr <= mem_rdata;
                        cnt   <= 8'h00;
                        if (mem_rdata[15:12] == JMP_OP) begin
                            state   <= JUMP;
                            Load_PC <= 1'b1;
                            addr    <= mem_rdata[4:0];
                        end else begin
                            state       <= HOLD;
                            instr_valid <= 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state     <= ERR;
                        cnt       <= 8'h00;
                        fetch_err <= 1'b1;
                    end else begin
                        cnt     <= cnt + 8'h01;
                        mem_req <= 1'b1;
                    end
                end
                JUMP, ADV: begin
                    if (run) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        if (instr[15:12] == HALT_OP) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state  <= ADV;
                            Inc_PC <= 1'b1;
                        end
                    end else begin
                        instr_valid <= 1'b1;
                    end
                end
                HALT: state <= HALT;
                ERR:  state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
